// File: rtl/cpu_pkg.sv
// Shared CPU definitions: ALU source modes, register index width, default XLEN.
package cpu_pkg;

  localparam int XLEN_DEF   = 32;
  localparam int REG_ADDR_W = 5;
  localparam int ALU_SRC_W  = 3;

  localparam logic [ALU_SRC_W-1:0] ALU_SRC_COMMON = 3'd0;
  localparam logic [ALU_SRC_W-1:0] ALU_SRC_IMM    = 3'd1;
  localparam logic [ALU_SRC_W-1:0] ALU_SRC_LINK   = 3'd2;
  localparam logic [ALU_SRC_W-1:0] ALU_SRC_LUI    = 3'd3;
  localparam logic [ALU_SRC_W-1:0] ALU_SRC_AUIPC  = 3'd4;

  // rs1 feeds op1 only in the register/register and register/immediate modes
  function automatic logic src_uses_rs1(input logic [ALU_SRC_W-1:0] mode);
    return (mode == ALU_SRC_COMMON) || (mode == ALU_SRC_IMM);
  endfunction

endpackage

// File: rtl/operand_forward_mux.sv
// Priority search over forwarding sources for one source register.
// Lowest index (youngest stage) wins; a pending match blocks older sources.
module operand_forward_mux
  import cpu_pkg::*;
#(
  parameter int XLEN    = XLEN_DEF,
  parameter int NUM_FWD = 2
) (
  input  logic [REG_ADDR_W-1:0]                addr,
  input  logic [XLEN-1:0]                      rf_data,
  input  logic [NUM_FWD-1:0]                   fwd_valid,
  input  logic [NUM_FWD-1:0]                   fwd_pending,
  input  logic [NUM_FWD-1:0][REG_ADDR_W-1:0]   fwd_rd,
  input  logic [NUM_FWD-1:0][XLEN-1:0]         fwd_data,
  output logic [XLEN-1:0]                      data,
  output logic                                 hazard
);

  // Walk oldest to youngest so the youngest match overrides; x0 never matches
  always_comb begin
    data   = rf_data;
    hazard = 1'b0;
    for (int i = NUM_FWD - 1; i >= 0; i--) begin
      if (addr != '0 && fwd_valid[i] && fwd_rd[i] == addr) begin
        data   = fwd_data[i];
        hazard = fwd_pending[i];
      end
    end
  end

endmodule

// File: rtl/alu_operand_stage.sv
// ID/EX operand register: mode-based operand select with forwarding,
// load-use stall, valid/ready on both sides, flush and stall counter.
module alu_operand_stage
  import cpu_pkg::*;
#(
  parameter int XLEN    = XLEN_DEF,
  parameter int NUM_FWD = 2,
  parameter int PC_INC  = 4,
  parameter int CNT_W   = 16
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               in_valid,
  output logic                               in_ready,
  input  logic [ALU_SRC_W-1:0]               alu_src,
  input  logic                               is_store,
  input  logic [REG_ADDR_W-1:0]              rs1_addr,
  input  logic [REG_ADDR_W-1:0]              rs2_addr,
  input  logic [XLEN-1:0]                    rs1_data,
  input  logic [XLEN-1:0]                    rs2_data,
  input  logic [XLEN-1:0]                    imm,
  input  logic [XLEN-1:0]                    pc,
  input  logic [NUM_FWD-1:0]                 fwd_valid,
  input  logic [NUM_FWD-1:0]                 fwd_pending,
  input  logic [NUM_FWD-1:0][REG_ADDR_W-1:0] fwd_rd,
  input  logic [NUM_FWD-1:0][XLEN-1:0]       fwd_data,
  input  logic                               flush,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic [XLEN-1:0]                    op1,
  output logic [XLEN-1:0]                    op2,
  output logic [XLEN-1:0]                    store_data,
  output logic                               illegal,
  output logic [CNT_W-1:0]                   stall_count
);

  typedef struct packed {
    logic [XLEN-1:0] op1;
    logic [XLEN-1:0] op2;
    logic [XLEN-1:0] store_data;
    logic            illegal;
  } opnd_t;

  // Index 0 = rs1, index 1 = rs2
  logic [1:0][REG_ADDR_W-1:0] src_addr;
  logic [1:0][XLEN-1:0]       src_rf;
  logic [1:0][XLEN-1:0]       src_fwd;
  logic [1:0]                 src_haz;
  logic [1:0]                 src_used;

  assign src_addr = {rs2_addr, rs1_addr};
  assign src_rf   = {rs2_data, rs1_data};

  generate
    for (genvar s = 0; s < 2; s++) begin : g_src
      operand_forward_mux #(
        .XLEN    (XLEN),
        .NUM_FWD (NUM_FWD)
      ) u_fwd (
        .addr        (src_addr[s]),
        .rf_data     (src_rf[s]),
        .fwd_valid   (fwd_valid),
        .fwd_pending (fwd_pending),
        .fwd_rd      (fwd_rd),
        .fwd_data    (fwd_data),
        .data        (src_fwd[s]),
        .hazard      (src_haz[s])
      );
    end
  endgenerate

  logic  hazard;
  logic  capture;
  opnd_t nxt;
  opnd_t cur;

  // Only operands the selected mode actually consumes can stall the stage
  always_comb begin
    src_used[0] = src_uses_rs1(alu_src) && (rs1_addr != '0);
    src_used[1] = ((alu_src == ALU_SRC_COMMON) || is_store) && (rs2_addr != '0);
  end

  assign hazard   = in_valid && |(src_used & src_haz);
  assign in_ready = !hazard && (!out_valid || out_ready);
  assign capture  = in_valid && in_ready && !flush;

  // Operand selection by ALU source mode; illegal modes zero both operands
  always_comb begin
    nxt         = '0;
    nxt.illegal = 1'b0;
    case (alu_src)
      ALU_SRC_COMMON: begin nxt.op1 = src_fwd[0]; nxt.op2 = src_fwd[1]; end
      ALU_SRC_IMM:    begin nxt.op1 = src_fwd[0]; nxt.op2 = imm;        end
      ALU_SRC_LINK:   begin nxt.op1 = pc;         nxt.op2 = XLEN'(PC_INC); end
      ALU_SRC_LUI:    begin nxt.op1 = '0;         nxt.op2 = imm;        end
      ALU_SRC_AUIPC:  begin nxt.op1 = pc;         nxt.op2 = imm;        end
      default:        nxt.illegal = 1'b1;
    endcase
    nxt.store_data = is_store ? src_fwd[1] : '0;
  end

  // Operand register and valid: flush drops validity but keeps the data
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      cur       <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (capture) begin
      out_valid <= 1'b1;
      cur       <= nxt;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // Saturating count of hazard cycles; survives flush
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_count <= '0;
    end else if (hazard && stall_count != '1) begin
      stall_count <= stall_count + 1'b1;
    end
  end

  assign op1        = cur.op1;
  assign op2        = cur.op2;
  assign store_data = cur.store_data;
  assign illegal    = cur.illegal;

endmodule
